cdc_handshake_tx: RTL

- Source-domain end of a two-phase (toggle) request/acknowledge crossing for multi-bit words.
- Accepts a word through a valid/ready port, latches it onto a held-stable bus, and toggles a request line to the destination domain.
- Waits for the destination's acknowledge toggle, resynchronised internally into clk, before the next word is accepted.
- Adds an optional acknowledge timeout with a sticky error flag, and a completed-transfer counter for status readback.

---
 rtl/cdc_handshake_tx_pkg.sv | 10 +
 rtl/cdc_handshake_tx_if.sv | 21 ++
 rtl/cdc_sync_bit.sv | 21 ++
 rtl/cdc_handshake_tx.sv | 117 +++++++++++
 4 files changed

// File: rtl/cdc_handshake_tx_pkg.sv
// Shared types for the source side of the toggle request/acknowledge crossing.
package cdc_handshake_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ERR  = 2'd2
    } tx_state_t;

endpackage

// File: rtl/cdc_handshake_tx_if.sv
// Word-transfer port: upstream valid/ready side plus the crossing data/req/ack lines.
interface cdc_handshake_tx_if #(
    parameter int DW = 16
);
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] xfer_data;
    logic          xfer_req;
    logic          xfer_ack;

    modport slave (
        input  in_data, in_valid, xfer_ack,
        output in_ready, xfer_data, xfer_req
    );

    modport master (
        output in_data, in_valid, xfer_ack,
        input  in_ready, xfer_data, xfer_req
    );
endinterface

// File: rtl/cdc_sync_bit.sv
// Single-bit multi-flop synchronizer; plain flop chain so it can be shared with the receive side.
module cdc_sync_bit #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);
    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];
endmodule

// File: rtl/cdc_handshake_tx.sv
// Source-domain end of a two-phase request/acknowledge crossing with ack timeout and transfer count.
//   state   | meaning
//   ST_IDLE | phases match; accept a word when in_valid
//   ST_WAIT | request toggled, waiting for synchronised ack toggle
//   ST_ERR  | ack timed out; err held until err_clr with phases matching
module cdc_handshake_tx
    import cdc_handshake_tx_pkg::*;
#(
    parameter int DW          = 16,
    parameter int SYNC_STAGES = 2,
    parameter int TIMEOUT     = 0,
    parameter int TW          = 16,
    parameter int CW          = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    cdc_handshake_tx_if.slave bus,
    output logic          busy,
    output logic          err,
    input  logic          err_clr,
    output logic [CW-1:0] xfer_count
);
    localparam logic [TW-1:0] TMO_LAST = TW'((TIMEOUT > 0) ? (TIMEOUT - 1) : 0);
    localparam bit            TMO_EN   = (TIMEOUT != 0);

    tx_state_t     state_q, state_d;
    logic [DW-1:0] data_q;
    logic          req_q;
    logic          err_q;
    logic [CW-1:0] count_q;
    logic [TW-1:0] tmo_q;
    logic          ack_s;
    logic          phase_ok;
    logic          in_ready_c;
    logic          accept, complete, fire, clear_err;

    cdc_sync_bit #(.STAGES(SYNC_STAGES)) u_ack_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (bus.xfer_ack),
        .q     (ack_s)
    );

    assign phase_ok = (ack_s == req_q);

    always_comb begin
        state_d    = state_q;
        in_ready_c = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        fire       = 1'b0;
        clear_err  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                in_ready_c = phase_ok;
                if (bus.in_valid && phase_ok) begin
                    accept  = 1'b1;
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // A matching ack wins over a timeout firing on the same cycle.
                if (phase_ok) begin
                    complete = 1'b1;
                    state_d  = ST_IDLE;
                end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
                    fire    = 1'b1;
                    state_d = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr && phase_ok) begin
                    clear_err = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            data_q  <= '0;
            req_q   <= 1'b0;
            err_q   <= 1'b0;
            count_q <= '0;
            tmo_q   <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                data_q <= bus.in_data;
                req_q  <= ~req_q;
            end
            if (fire) begin
                err_q <= 1'b1;
            end else if (clear_err) begin
                err_q <= 1'b0;
            end
            if (complete) begin
                count_q <= count_q + CW'(1);
            end
            if (accept) begin
                tmo_q <= '0;
            end else if (TMO_EN && (state_q == ST_WAIT) && !phase_ok) begin
                tmo_q <= tmo_q + TW'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.xfer_data = data_q;
    assign bus.xfer_req  = req_q;
    assign busy          = !phase_ok;
    assign err           = err_q;
    assign xfer_count    = count_q;
endmodule
